mips_mem_arbiter: RTL
=====================

Name: mips_mem_arbiter

Overview:
- Shares one single-port, fixed-latency word memory between the MIPS32 instruction-fetch stage (IF port) and the load/store stage (DM port).
- Fixed priority to DM, with an anti-starvation override for IF.
- Allows one outstanding access at a time.
- A halt input freezes new fetch grants while data traffic drains.

Parameters:
ADDR_W, 10, word-address width
DATA_W, 32, data width
MEM_LAT, 1, cycles from mem_en to valid mem_rdata (>=1)
STARVE_MAX, 4, consecutive DM grants tolerated while IF waits
MEM_DEPTH, 1024, number of valid words (used only with bounds check)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
halt  in  1  level; blocks new IF grants
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  one-cycle grant pulse
if_valid  out  1  one-cycle response pulse
if_rdata  out  DATA_W  fetched instruction
if_err  out  1  bounds error with if_valid
dm_req  in  1  data request, held until dm_gnt
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data word address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  one-cycle grant pulse
dm_valid  out  1  one-cycle completion pulse (loads and stores)
dm_rdata  out  DATA_W  load data; 0 for stores
dm_err  out  1  bounds error with dm_valid
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, latency counter 0, starve_cnt 0, owner cleared. Any in-flight response is dropped; no valid pulse after reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Select a winner among eligible requests. IF is eligible only when if_req=1 and halt=0.
  - Both eligible: DM wins, unless starve_cnt==STARVE_MAX, in which case IF wins.
  - The winner's gnt and mem_en (plus mem_we/addr/wdata, combinational from the winner) are asserted in the same cycle T.
  - Latch the owner and load counter=MEM_LAT, then go to WAIT.
  - No request: stay in IDLE with all strobes 0.
- WAIT:
  - Decrement the counter each cycle.
  - At cycle T+MEM_LAT: register mem_rdata (forced to 0 for stores) into the owner's rdata, then go to RESP.
- RESP (cycle T+MEM_LAT+1):
  - The owner's valid pulses for 1 cycle with rdata held.
  - Arbitration runs as in IDLE, so a new grant may coincide with valid. Back-to-back period is MEM_LAT+1 cycles.
- rdata outputs hold their last value after valid; only the owner's rdata updates.
- Grant-to-valid latency: MEM_LAT+1 cycles, for both ports.
- No grant is issued in WAIT; requests stay pending.
- Dropping req before gnt is legal and consumes nothing.
- starve_cnt:
  - Increments on a DM grant when if_req=1 and halt=0 at that cycle.
  - Clears on any IF grant, or on a DM grant with IF not eligible.
  - Saturates at STARVE_MAX.
- halt asserted during an outstanding fetch: that fetch still completes with if_valid. halt never affects DM.
- Simultaneous halt rise and if_req in IDLE: no IF grant.

Optional Feature:
Macro MEM_ARB_BOUNDS_CHK_EN.
- Defined: at grant, if addr>=MEM_DEPTH, the grant is still issued but mem_en stays 0 (no memory access, no store). After MEM_LAT+1 cycles the owner's valid pulses with rdata=0 and err=1. The starvation logic treats it as a normal grant.
- Undefined: no check; if_err/dm_err tied 0; MEM_DEPTH unused.

Decomposition:
- Package mips_mem_pkg:
  - state enum (IDLE, WAIT, RESP)
  - owner enum (OWN_IF, OWN_DM)
  - DATA_W default constant
  - mem request struct {we, addr, wdata}
- Single module; no sub-module needed. The latency counter and response registers stay inline.

Test Plan:
- Fetch, MEM_LAT=1, Mem[0]=32'h2801000a: if_req, if_addr=0 at cycle 0 -> if_gnt and mem_en at cycle 0; if_valid=1 with if_rdata=32'h2801000a at cycle 2; dm outputs stay 0.
- Contention: if_req and dm_req (load addr 5, Mem[5]=32'h00832800) together -> dm_gnt first, dm_valid with 32'h00832800; if_gnt in the RESP cycle of the DM access.
- Starvation, STARVE_MAX=2: if_req held, dm_req held continuously -> grant order DM, DM, IF, DM, DM, IF.
- Halt: halt=1 with if_req held for 20 cycles -> if_gnt never asserted; a store dm_we=1, addr 7, data 32'h0ce77800 -> mem_we=1, dm_valid with dm_rdata=0; a subsequent load of addr 7 returns 32'h0ce77800.
- Reset mid-op: rst_n low at cycle T+1 after a DM grant -> all outputs 0 immediately; no dm_valid after release; next request granted from IDLE normally.
- With MEM_ARB_BOUNDS_CHK_EN, MEM_DEPTH=16: load addr 20 -> dm_gnt=1, mem_en=0, dm_valid with dm_err=1 and dm_rdata=0 at grant+MEM_LAT+1.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS instruction/data memory arbiter.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Fetch/data arbiter for one fixed-latency single-port memory, one access in flight.
// Optional address bounds check enabled by defining MEM_ARB_BOUNDS_CHK_EN.
//
// state | meaning
// IDLE  | no access in flight, arbitrating
// WAIT  | access in flight, counting down memory latency
// RESP  | owner's valid pulse; arbitration for the next access runs here too
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int SC_W  = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SC_W-1:0]   starve_q;
  logic              we_q, oob_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic [DATA_W-1:0] cap_data;
  logic              if_elig, dm_elig, pick_if, pick_dm, gnt, oob;
  mem_req_t          win;

  // Gating eligibility with rst_n keeps grants and strobes low while reset is held.
  always_comb begin
    if_elig = rst_n && if_req && !halt;
    dm_elig = rst_n && dm_req;
    pick_if = 1'b0;
    pick_dm = 1'b0;
    if (state_q != WAIT) begin
      if (dm_elig && !(if_elig && starve_q == SC_W'(STARVE_MAX))) pick_dm = 1'b1;
      else if (if_elig)                                          pick_if = 1'b1;
    end
    gnt = pick_if || pick_dm;
    win = '0;
    if (pick_dm) begin
      win.we    = dm_we;
      win.addr  = ADDR_W_DEF'(dm_addr);
      win.wdata = DATA_W_DEF'(dm_wdata);
    end else if (pick_if) begin
      win.addr  = ADDR_W_DEF'(if_addr);
    end
  end

`ifdef MEM_ARB_BOUNDS_CHK_EN
  assign oob = gnt && (32'(win.addr) >= 32'(MEM_DEPTH));
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: state_d = gnt ? WAIT : IDLE;
      WAIT:       if (cnt_q == CNT_W'(1)) state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  assign cap_data = (we_q || oob_q) ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      cnt_q      <= '0;
      starve_q   <= '0;
      we_q       <= 1'b0;
      oob_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        owner_q <= pick_dm ? OWN_DM : OWN_IF;
        cnt_q   <= CNT_W'(MEM_LAT);
        we_q    <= win.we;
        oob_q   <= oob;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == WAIT && cnt_q == CNT_W'(1)) begin
        if (owner_q == OWN_DM) dm_rdata_q <= cap_data;
        else                   if_rdata_q <= cap_data;
      end
      // A DM grant only counts against IF when IF was actually able to go.
      if (pick_if) begin
        starve_q <= '0;
      end else if (pick_dm) begin
        if (!if_elig)                             starve_q <= '0;
        else if (starve_q != SC_W'(STARVE_MAX))   starve_q <= starve_q + 1'b1;
      end
    end
  end

  assign if_gnt    = pick_if;
  assign dm_gnt    = pick_dm;
  assign mem_en    = gnt && !oob;
  assign mem_we    = mem_en && win.we;
  assign mem_addr  = mem_en ? ADDR_W'(win.addr) : '0;
  assign mem_wdata = mem_we ? DATA_W'(win.wdata) : '0;
  assign if_valid  = (state_q == RESP) && (owner_q == OWN_IF);
  assign dm_valid  = (state_q == RESP) && (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

`ifdef MEM_ARB_BOUNDS_CHK_EN
  assign if_err = if_valid && oob_q;
  assign dm_err = dm_valid && oob_q;
`else
  assign if_err = 1'b0;
  assign dm_err = 1'b0;
`endif

endmodule
